// File: rtl/spi_mem_master.sv
// SPI mode-0 master moving one {rwb, addr, data} frame per request, MSB first.
// Define SPI_MISO_FALL_SAMPLE_EN to sample MISO on falling SCLK instead of rising.
module spi_mem_master #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start_i,
  input  logic              rwb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sclk_o,
  output logic              csb_o,
  output logic              mosi_o,
  input  logic              miso_i
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);
`ifdef SPI_MISO_FALL_SAMPLE_EN
  localparam bit FALL_SAMPLE = 1'b1;
`else
  localparam bit FALL_SAMPLE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_W-2:0]    tx_sr;  // frame minus its MSB, which goes straight to mosi
  logic [DATA_W-1:0]     rx_sr;
  logic                  rd_flag;
  logic                  div_end;

  assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rd_flag <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rdata_o <= '0;
      sclk_o  <= 1'b0;
      csb_o   <= 1'b1;
      mosi_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          csb_o  <= 1'b1;
          sclk_o <= 1'b0;
          if (start_i) begin
            tx_sr   <= {addr_i, rwb_i ? {DATA_W{1'b0}} : wdata_i};
            rd_flag <= rwb_i;
            mosi_o  <= rwb_i;
            csb_o   <= 1'b0;
            busy_o  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk_o  <= 1'b1;
            if (!FALL_SAMPLE) rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (sclk_o) begin
              sclk_o <= 1'b0;
              if (FALL_SAMPLE) rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
              mosi_o <= (bit_cnt == LAST_BIT) ? 1'b0 : tx_sr[FRAME_W-2];
              tx_sr  <= {tx_sr[FRAME_W-3:0], 1'b0};
            end else if (bit_cnt == LAST_BIT) begin
              // last bit's low half has elapsed
              state <= HOLD;
            end else begin
              sclk_o  <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
              if (!FALL_SAMPLE) rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            csb_o   <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            if (rd_flag) rdata_o <= rx_sr;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: slave model on the SPI pins plus a frame-level reference.
module tb_spi_mem_master;
`ifdef SPI_MISO_FALL_SAMPLE_EN
  localparam int CLK_DIV = 1;
  localparam bit FALL    = 1'b1;
`else
  localparam int CLK_DIV = 2;
  localparam bit FALL    = 1'b0;
`endif
  localparam int LAT    = 66 * CLK_DIV + 1;  // accept edge counted as edge 1
  localparam int PERIOD = 66 * CLK_DIV + 2;

  logic        clk = 1'b0, resetb = 1'b0, start = 1'b0, rwb = 1'b0;
  logic [14:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        miso;
  logic        busy, done, sclk, csb, mosi;
  logic [15:0] rdata;

  int          tests = 0, fails = 0;
  logic [31:0] slv_word = '0;
  int          rises = 0, falls = 0, last_rises = 0;
  logic [31:0] cap = '0, last_cap = '0;
  logic [15:0] model_rdata = '0;

  always #5 clk = ~clk;

  spi_mem_master #(.CLK_DIV(CLK_DIV), .ADDR_W(15), .DATA_W(16)) dut (
    .clk(clk), .resetb(resetb), .start_i(start), .rwb_i(rwb), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata),
    .sclk_o(sclk), .csb_o(csb), .mosi_o(mosi), .miso_i(miso)
  );

  // MOSI captured on SCLK rising edges; snapshot taken when CS deasserts
  always @(posedge sclk or posedge csb) begin
    if (csb) begin
      last_cap = cap; last_rises = rises; cap = '0; rises = 0;
    end else begin
      cap = {cap[30:0], mosi}; rises++;
    end
  end

  always @(negedge sclk or posedge csb) begin
    if (csb) falls = 0;
    else     falls++;
  end

  // Slave shifts out slv_word MSB first: on falling edges, or on rising edges for fall sampling
  always_comb begin
    miso = 1'b0;
    if (FALL) begin
      if (rises > 0 && rises <= 32) miso = slv_word[32-rises];
    end else if (falls < 32) begin
      miso = slv_word[31-falls];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    bit seen = 0;
    n = 1;
    while (!seen && n < 3000) begin
      @(posedge clk); n++; #1;
      if (done) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic wait_rises(input int k);
    int c = 0;
    while (rises < k && c < 3000) begin @(negedge clk); c++; end
    chk("wait_rises_timeout", (c < 3000), 1'b1);
  endtask

  task automatic run_frame(input logic r, input logic [14:0] a, input logic [15:0] w,
                           input logic [31:0] word);
    logic [31:0] exp_frame;
    int n;
    exp_frame = {r, a, r ? 16'h0000 : w};
    slv_word  = word;
    @(negedge clk); start = 1'b1; rwb = r; addr = a; wdata = w;
    @(posedge clk); #1;
    chk("accept_busy_csb", {busy, csb}, 2'b10);
    @(negedge clk);
    start = 1'b0; rwb = 1'($urandom); addr = 15'($urandom); wdata = 16'($urandom);
    wait_done(n);
    chk("done_latency", n, LAT);
    if (r) model_rdata = word[15:0];
    chk("mosi_frame", last_cap, exp_frame);
    chk("sclk_pulses", last_rises, 32);
    chk("rdata", rdata, model_rdata);
    chk("done_csb_busy", {csb, busy}, 2'b10);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int n, nd, csb_hi, min_gap, low_cnt, exp_frames;
    bit was_low, saw_done;
    logic [31:0] word;

    repeat (3) @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", {csb, sclk, mosi, busy, done, rdata}, {5'b10000, 16'h0000});
    end

    run_frame(1'b0, 15'h1234, 16'hBEEF, 32'($urandom));
    run_frame(1'b1, 15'h7FFF, 16'h5555, {16'($urandom), 16'hA5C3});
    run_frame(1'b1, 15'h0001, 16'h0000, {16'($urandom), 16'h3C5A});
    run_frame(1'b0, 15'h0000, 16'hFFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      run_frame(1'($urandom), 15'($urandom), 16'($urandom), 32'($urandom));

    // start held high: back-to-back frames with a 2-cycle CS-high gap
    word = 32'($urandom);
    slv_word = word;
    nd = 0; csb_hi = 0; min_gap = 999; was_low = 0;
    @(negedge clk); start = 1'b1; rwb = 1'b1; addr = 15'($urandom);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (csb) csb_hi++;
      else begin
        if (was_low && csb_hi > 0 && csb_hi < min_gap) min_gap = csb_hi;
        csb_hi = 0; was_low = 1;
      end
    end
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    exp_frames = 399 / PERIOD + 1;
    model_rdata = word[15:0];
    chk("held_start_frames", nd, exp_frames);
    chk("held_start_gap", min_gap, 2);
    chk("held_start_rdata", rdata, model_rdata);

    // start pulsed mid-SHIFT is ignored
    slv_word = 32'($urandom);
    @(negedge clk); start = 1'b1; rwb = 1'b0; addr = 15'h2AAA; wdata = 16'h1357;
    @(negedge clk); start = 1'b0;
    wait_rises(5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(n);
    chk("midpulse_latency", n >= 0, 1'b1);
    chk("midpulse_frame", last_cap, {1'b0, 15'h2AAA, 16'h1357});
    low_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (!csb) low_cnt++;
    end
    chk("midpulse_no_second_frame", low_cnt, 0);

    // async reset mid-SHIFT at bit 10
    slv_word = 32'($urandom);
    @(negedge clk); start = 1'b1; rwb = 1'b1; addr = 15'($urandom);
    @(negedge clk); start = 1'b0;
    wait_rises(10);
    @(negedge clk); #2; resetb = 1'b0; #1;
    chk("abort_immediate", {csb, sclk, busy, done}, 4'b1000);
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    resetb = 1'b1;
    model_rdata = '0;
    repeat (PERIOD) begin @(negedge clk); if (done) saw_done = 1; end
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_rdata_zero", rdata, model_rdata);
    run_frame(1'b1, 15'($urandom), 16'($urandom), 32'($urandom));
    run_frame(1'b0, 15'($urandom), 16'($urandom), 32'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
